stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
Controller for the 0-99 s seven-segment stopwatch on the 50 MHz CPLD board. It turns two push-buttons into start/stop/clear commands and runs a Run/Pause/Done state machine. It generates the one-second count enable internally and keeps a two-digit BCD count. It time-multiplexes one shared segment bus between the tens and ones digits.

Parameters:
TICKS_PER_SEC, 50_000_000, clkIn cycles per counted second; minimum 2.
SCAN_TICKS, 50_000, clkIn cycles each digit owns the segment bus; minimum 1.
MAX_COUNT, 99, terminal count in seconds; range 1..99.

Ports:
clkIn  input  1  system clock, 50 MHz
rst  input  1  asynchronous reset, active-high
btnStartStop  input  1  raw start/stop push-button, active-high, asynchronous to clkIn
btnClear  input  1  raw clear push-button, active-high, asynchronous to clkIn
seg  output  7  segment drive, active-high; bit0 = a … bit6 = g
digitSel  output  2  one-hot digit enable, active-high; bit0 = ones, bit1 = tens
tens  output  4  BCD tens digit of the count
ones  output  4  BCD ones digit of the count
running  output  1  high while in RUN
done  output  1  high while in DONE

Behaviour:
- Reset (async, rst high) forces:
  - state IDLE; tens = ones = 0; prescaler = 0; scan counter = 0.
  - digitSel = 2'b01; seg = pattern for 0 (7'h3F); running = 0; done = 0.
  - Synchronizer flops and previous-sample flops cleared.
  - Reset asserted mid-RUN aborts immediately, with no further ticks.
- Button path:
  - Each button passes through a 2-flop synchronizer, then a rising-edge detect against a third flop.
  - The command pulse is one cycle wide, 3 clkIn edges after the input rises. Holding a button gives one pulse only.
  - No debounce filter; upstream board logic guarantees clean edges.
- States: IDLE, RUN, PAUSE, DONE.
  - clearPulse in any state → IDLE, count 00, prescaler 0.
  - startPulse: IDLE → RUN; RUN → PAUSE; PAUSE → RUN; DONE → ignored.
  - Start and clear pulses in the same cycle: clear wins.
- Prescaler:
  - Counts only in RUN; holds its value in PAUSE, so resume continues the partial second.
  - When prescaler = TICKS_PER_SEC-1 in RUN: prescaler → 0 and the count increments on that same edge.
  - First increment happens TICKS_PER_SEC cycles after entering RUN from IDLE.
- Count:
  - BCD. When ones = 9: ones → 0 and tens +1.
  - When the increment reaches MAX_COUNT (BCD compare), state → DONE on the same edge and the count holds at MAX_COUNT.
  - No wrap to 00; the prescaler stops in DONE.
- Status outputs: running = (state == RUN); done = (state == DONE); both registered from the state.
- Display scan:
  - Free-running in all states except reset.
  - When the scan counter reaches SCAN_TICKS-1: it wraps to 0 and digitSel toggles between 01 and 10.
  - seg is registered: it shows the digit that digitSel selects in the same cycle, with no mismatch cycle.
  - Decode table for 0-9 (g..a): 3F,06,5B,4F,66,6D,7D,07,7F,6F. BCD values 10-15 cannot occur; they decode to 7'h00.
- Output update: tens and ones change only on a tick, a clear, or reset.

Test Plan:
(Use TICKS_PER_SEC=10, SCAN_TICKS=4, MAX_COUNT=99 unless noted.)
1. Reset → tens=0, ones=0, digitSel=01, seg=3F, running=0, done=0. Release reset and hold 40 cycles → digitSel toggles every 4 cycles; seg=3F throughout.
2. Pulse btnStartStop 1 cycle → running=1 three edges later. ones=1 after 10 further cycles, ones=9 after 90, tens=1/ones=0 after 100.
3. RUN for 25 cycles (count 02, prescaler 5), start pulse → PAUSE and count frozen for 50 cycles. Start pulse again → count 03 after exactly 5 RUN cycles.
4. RUN to 99 → done=1, running=0, count 99 held for 100 cycles. Start pulse ignored. Clear pulse → IDLE, count 00, done=0.
5. btnStartStop and btnClear rise in the same cycle while in RUN at count 07 → IDLE, count 00, running=0.
6. Assert rst asynchronously mid-RUN at count 42 (between clock edges) → outputs at reset values immediately. After release, no tick until a new start pulse.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Two-button 0-99 s stopwatch: button sync/edge detect, IDLE/RUN/PAUSE/DONE control,
// internal one-second prescaler, BCD count and a two-digit multiplexed segment driver.
module stopwatch_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned SCAN_TICKS    = 50_000,
  parameter int unsigned MAX_COUNT     = 99
) (
  input  logic       clkIn,
  input  logic       rst,
  input  logic       btnStartStop,
  input  logic       btnClear,
  output logic [6:0] seg,
  output logic [1:0] digitSel,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       done
);

  localparam int unsigned PRE_W  = $clog2(TICKS_PER_SEC);
  localparam int unsigned SCAN_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;

  localparam logic [3:0] MAX_TENS = 4'(MAX_COUNT / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_COUNT % 10);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [PRE_W-1:0]  r_pre;
  logic [SCAN_W-1:0] r_scan;
  logic [3:0]        r_tens;
  logic [3:0]        r_ones;
  logic [1:0]        r_sel;
  logic [6:0]        r_seg;
  logic              r_running;
  logic              r_done;

  logic r_ss_meta, r_ss_sync, r_ss_prev;
  logic r_clr_meta, r_clr_sync, r_clr_prev;

  logic [1:0]        w_state_nxt;
  logic [PRE_W-1:0]  w_pre_nxt;
  logic [SCAN_W-1:0] w_scan_nxt;
  logic [3:0]        w_tens_nxt;
  logic [3:0]        w_ones_nxt;
  logic [1:0]        w_sel_nxt;
  logic [3:0]        w_digit;
  logic [6:0]        w_seg_nxt;
  logic              w_tick;
  logic              w_hit_max;
  logic              w_start_pulse;
  logic              w_clr_pulse;

  assign w_start_pulse = r_ss_sync & ~r_ss_prev;
  assign w_clr_pulse   = r_clr_sync & ~r_clr_prev;

  // Button synchronizers and rising-edge history
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      r_ss_meta  <= 1'b0;
      r_ss_sync  <= 1'b0;
      r_ss_prev  <= 1'b0;
      r_clr_meta <= 1'b0;
      r_clr_sync <= 1'b0;
      r_clr_prev <= 1'b0;
    end else begin
      r_ss_meta  <= btnStartStop;
      r_ss_sync  <= r_ss_meta;
      r_ss_prev  <= r_ss_sync;
      r_clr_meta <= btnClear;
      r_clr_sync <= r_clr_meta;
      r_clr_prev <= r_clr_sync;
    end
  end

  // Next state, prescaler and BCD count; clear overrides everything else
  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_tens_nxt  = r_tens;
    w_ones_nxt  = r_ones;
    w_tick      = 1'b0;
    w_hit_max   = 1'b0;

    if (r_state == ST_RUN) begin
      if (r_pre == PRE_W'(TICKS_PER_SEC - 1)) begin
        w_pre_nxt = '0;
        w_tick    = 1'b1;
      end else begin
        w_pre_nxt = r_pre + PRE_W'(1);
      end
    end

    if (w_tick) begin
      if (r_ones == 4'd9) begin
        w_ones_nxt = 4'd0;
        w_tens_nxt = r_tens + 4'd1;
      end else begin
        w_ones_nxt = r_ones + 4'd1;
      end
      if ((w_tens_nxt == MAX_TENS) && (w_ones_nxt == MAX_ONES)) begin
        w_hit_max   = 1'b1;
        w_state_nxt = ST_DONE;
      end
    end

    if (w_clr_pulse) begin
      w_state_nxt = ST_IDLE;
      w_pre_nxt   = '0;
      w_tens_nxt  = 4'd0;
      w_ones_nxt  = 4'd0;
    end else if (w_start_pulse && !w_hit_max) begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_RUN;
        ST_RUN:   w_state_nxt = ST_PAUSE;
        ST_PAUSE: w_state_nxt = ST_RUN;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  // Scan timing and segment decode of the digit selected on the same edge
  always_comb begin
    w_scan_nxt = r_scan + SCAN_W'(1);
    w_sel_nxt  = r_sel;
    if (r_scan == SCAN_W'(SCAN_TICKS - 1)) begin
      w_scan_nxt = '0;
      w_sel_nxt  = {r_sel[0], r_sel[1]};
    end
    w_digit = w_sel_nxt[1] ? w_tens_nxt : w_ones_nxt;
    case (w_digit)
      4'd0:    w_seg_nxt = 7'h3F;
      4'd1:    w_seg_nxt = 7'h06;
      4'd2:    w_seg_nxt = 7'h5B;
      4'd3:    w_seg_nxt = 7'h4F;
      4'd4:    w_seg_nxt = 7'h66;
      4'd5:    w_seg_nxt = 7'h6D;
      4'd6:    w_seg_nxt = 7'h7D;
      4'd7:    w_seg_nxt = 7'h07;
      4'd8:    w_seg_nxt = 7'h7F;
      4'd9:    w_seg_nxt = 7'h6F;
      default: w_seg_nxt = 7'h00;
    endcase
  end

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pre     <= '0;
      r_scan    <= '0;
      r_tens    <= 4'd0;
      r_ones    <= 4'd0;
      r_sel     <= 2'b01;
      r_seg     <= 7'h3F;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pre     <= w_pre_nxt;
      r_scan    <= w_scan_nxt;
      r_tens    <= w_tens_nxt;
      r_ones    <= w_ones_nxt;
      r_sel     <= w_sel_nxt;
      r_seg     <= w_seg_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_done    <= (w_state_nxt == ST_DONE);
    end
  end

  assign seg      = r_seg;
  assign digitSel = r_sel;
  assign tens     = r_tens;
  assign ones     = r_ones;
  assign running  = r_running;
  assign done     = r_done;

endmodule
